// File: rtl/ola_synth_stream.sv
// Overlap-add synthesis: sums each frame's head with the previous frame's tail and streams HOP samples per frame.
// Frame input is stalled while the held hop is drained; the final frame also drains its tail, then the block parks in DONE.
module ola_synth_stream #(
  parameter int N          = 128,
  parameter int OVERLAP    = 64,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  frame_ready,
  input  logic                  do_en,
  input  logic [DATA_WIDTH-1:0] do_re,
  input  logic [DATA_WIDTH-1:0] do_im,
  input  logic                  do_last,
  output logic [DATA_WIDTH-1:0] dout_re,
  output logic [DATA_WIDTH-1:0] dout_im,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  done,
  output logic                  err
);

  localparam int HOP = N - OVERLAP;
  localparam int KW  = $clog2(N);
  localparam int BW  = (HOP > 1) ? $clog2(HOP) : 1;
  localparam int TW  = (OVERLAP > 1) ? $clog2(OVERLAP) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);
  localparam logic [KW-1:0] HOP_K  = KW'(HOP);
  localparam logic [KW-1:0] OVL_K  = KW'(OVERLAP);
  localparam logic [KW-1:0] ONE_K  = KW'(1);

  typedef enum logic [2:0] {IDLE, LOAD, EMIT, FLUSH, DONE} state_t;

  state_t                state, state_n;
  logic [KW-1:0]         k, k_n;
  logic [KW-1:0]         e, e_n;
  logic                  last, last_n;
  logic                  ld;
  logic [DATA_WIDTH-1:0] ld_re, ld_im;
  logic                  tail_clr;

  logic [DATA_WIDTH-1:0] hop_re  [HOP];
  logic [DATA_WIDTH-1:0] hop_im  [HOP];
  logic [DATA_WIDTH-1:0] tail_re [OVERLAP];
  logic [DATA_WIDTH-1:0] tail_im [OVERLAP];

  logic [KW-1:0] tk;
  logic [BW-1:0] k_b, e_b;
  logic [TW-1:0] k_t, tk_t, e_t;
  logic          accept, free, hs;

  assign frame_ready = (state == IDLE) || (state == LOAD);
  assign done        = (state == DONE);
  assign accept      = frame_ready && do_en;
  assign free        = !dout_valid || dout_ready;
  assign hs          = dout_valid && dout_ready;

  assign tk   = k - HOP_K;
  assign k_b  = k[BW-1:0];
  assign k_t  = k[TW-1:0];
  assign tk_t = tk[TW-1:0];
  assign e_b  = e[BW-1:0];
  assign e_t  = e[TW-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      k     <= '0;
      e     <= '0;
      last  <= 1'b0;
    end else begin
      state <= state_n;
      k     <= k_n;
      e     <= e_n;
      last  <= last_n;
    end
  end

  // e counts samples already loaded into the output register for the current phase.
  always_comb begin
    state_n  = state;
    k_n      = k;
    e_n      = e;
    last_n   = last;
    ld       = 1'b0;
    ld_re    = '0;
    ld_im    = '0;
    tail_clr = 1'b0;
    unique case (state)
      IDLE, LOAD: begin
        if (do_en) begin
          last_n = last | do_last;
          if (k == K_LAST) begin
            // buf[0] is already final, so preload it on the frame's closing edge.
            k_n     = '0;
            state_n = EMIT;
            ld      = 1'b1;
            ld_re   = hop_re[0];
            ld_im   = hop_im[0];
            e_n     = ONE_K;
          end else begin
            k_n     = k + ONE_K;
            state_n = LOAD;
          end
        end
      end
      EMIT: begin
        if (e != HOP_K) begin
          if (free) begin
            ld    = 1'b1;
            ld_re = hop_re[e_b];
            ld_im = hop_im[e_b];
            e_n   = e + ONE_K;
          end
        end else if (hs) begin
          if (last) begin
            state_n = FLUSH;
            ld      = 1'b1;
            ld_re   = tail_re[0];
            ld_im   = tail_im[0];
            e_n     = ONE_K;
          end else begin
            state_n = IDLE;
            e_n     = '0;
          end
        end
      end
      FLUSH: begin
        if (e != OVL_K) begin
          if (free) begin
            ld    = 1'b1;
            ld_re = tail_re[e_t];
            ld_im = tail_im[e_t];
            e_n   = e + ONE_K;
          end
        end else if (hs) begin
          state_n  = DONE;
          e_n      = '0;
          tail_clr = 1'b1;
        end
      end
      DONE: begin
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dout_re    <= '0;
      dout_im    <= '0;
      dout_valid <= 1'b0;
    end else if (ld) begin
      dout_re    <= ld_re;
      dout_im    <= ld_im;
      dout_valid <= 1'b1;
    end else if (hs) begin
      dout_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (do_en && !frame_ready) begin
      err <= 1'b1;
    end
  end

  // tail[j] is read at k=j and rewritten at k=HOP+j, which is never earlier since OVERLAP<=HOP.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < HOP; i++) begin
        hop_re[i] <= '0;
        hop_im[i] <= '0;
      end
      for (int i = 0; i < OVERLAP; i++) begin
        tail_re[i] <= '0;
        tail_im[i] <= '0;
      end
    end else begin
      if (accept) begin
        if (k < OVL_K) begin
          hop_re[k_b] <= do_re + tail_re[k_t];
          hop_im[k_b] <= do_im + tail_im[k_t];
        end else if (k < HOP_K) begin
          hop_re[k_b] <= do_re;
          hop_im[k_b] <= do_im;
        end else begin
          tail_re[tk_t] <= do_re;
          tail_im[tk_t] <= do_im;
        end
      end
      if (tail_clr) begin
        for (int i = 0; i < OVERLAP; i++) begin
          tail_re[i] <= '0;
          tail_im[i] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ola_synth_stream.sv
// Directed bench for ola_synth_stream: frame sequences, wrap, backpressure, gapped input, reset abort.
module tb_ola_synth_stream;
  localparam int N   = 128;
  localparam int OV  = 64;
  localparam int DW  = 16;
  localparam int HOP = N - OV;

  logic          clock = 1'b0;
  logic          reset;
  logic          frame_ready;
  logic          do_en;
  logic [DW-1:0] do_re, do_im;
  logic          do_last;
  logic [DW-1:0] dout_re, dout_im;
  logic          dout_valid;
  logic          dout_ready;
  logic          done;
  logic          err;

  ola_synth_stream #(.N(N), .OVERLAP(OV), .DATA_WIDTH(DW)) dut (
    .clock      (clock),
    .reset      (reset),
    .frame_ready(frame_ready),
    .do_en      (do_en),
    .do_re      (do_re),
    .do_im      (do_im),
    .do_last    (do_last),
    .dout_re    (dout_re),
    .dout_im    (dout_im),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .done       (done),
    .err        (err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [31:0]   got_q[$];
  logic [31:0]   exp_q[$];
  logic [DW-1:0] mt_re[OV];
  logic [DW-1:0] mt_im[OV];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Every accepted output sample, captured mid-cycle.
  always @(negedge clock) begin
    if (dout_valid && dout_ready) got_q.push_back({dout_re, dout_im});
  end

  task automatic clear_model();
    got_q.delete();
    exp_q.delete();
    for (int j = 0; j < OV; j++) begin
      mt_re[j] = '0;
      mt_im[j] = '0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_valid", 32'(dout_valid), 0);
    chk("rst_dout", {dout_re, dout_im}, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    clear_model();
  endtask

  // Sample k carries re=br+sr*k, im=bi+si*k; gap idle cycles follow each strobe.
  task automatic send(input int br, input int sr, input int bi, input int si,
                      input bit lst, input int gap);
    logic [DW-1:0] vr, vi, sr_v, si_v;
    logic [DW-1:0] nt_re[OV];
    logic [DW-1:0] nt_im[OV];
    for (int k = 0; k < N; k++) begin
      int cyc = 0;
      vr = DW'(br + sr * k);
      vi = DW'(bi + si * k);
      if (k < OV) begin
        sr_v = vr + mt_re[k];
        si_v = vi + mt_im[k];
        exp_q.push_back({sr_v, si_v});
      end else if (k < HOP) begin
        exp_q.push_back({vr, vi});
      end else begin
        nt_re[k-HOP] = vr;
        nt_im[k-HOP] = vi;
      end
      while (!frame_ready && cyc < 2000) begin
        @(posedge clock);
        #1;
        cyc++;
      end
      if (!frame_ready) chk("frame_ready_wait", 32'(frame_ready), 1);
      do_en   = 1'b1;
      do_re   = vr;
      do_im   = vi;
      do_last = lst && (k == 0);
      @(posedge clock);
      #1;
      do_en   = 1'b0;
      do_last = 1'b0;
      repeat (gap) begin
        @(posedge clock);
        #1;
      end
    end
    for (int j = 0; j < OV; j++) begin
      mt_re[j] = nt_re[j];
      mt_im[j] = nt_im[j];
    end
    if (lst) begin
      for (int j = 0; j < OV; j++) begin
        exp_q.push_back({mt_re[j], mt_im[j]});
        mt_re[j] = '0;
        mt_im[j] = '0;
      end
    end
  endtask

  task automatic wait_outputs(input int n);
    int cyc = 0;
    while (got_q.size() < n && cyc < 2000) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    if (got_q.size() < n) chk("wait_outputs", got_q.size(), n);
  endtask

  task automatic drain(input int n, input string tag);
    logic [31:0] g, x;
    int cyc = 0;
    while (got_q.size() < n && cyc < n * 8 + 300) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    if (got_q.size() < n) chk({tag, "_count"}, got_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (got_q.size() == 0) break;
      g = got_q.pop_front();
      x = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      chk($sformatf("%s[%0d]", tag, i), g, x);
    end
  endtask

  initial begin
    logic [DW-1:0] h_re, h_im;
    logic          h_v;
    bit            stable;
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] h_re, h_im;
    logic          h_v;
    bit            stable;
    do_en = 1'b0; do_re = '0; do_im = '0; do_last = 1'b0; dout_ready = 1'b1;
    clear_model();
    do_reset();
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_frame_ready", 32'(frame_ready), 1);

    // Frame A: all (1,0), not final.
    send(1, 0, 0, 0, 1'b0, 0);
    drain(HOP, "A");
    chk("A_frame_ready", 32'(frame_ready), 1);
    chk("A_done", 32'(done), 0);
    chk("A_valid_drop", 32'(dout_valid), 0);

    // Frame B: (2,-1), final; hop = 3,-1 then flush 2,-1.
    send(2, 0, -1, 0, 1'b1, 0);
    drain(HOP + OV, "B");
    chk("B_done", 32'(done), 1);
    chk("B_frame_ready", 32'(frame_ready), 0);
    chk("B_err_before", 32'(err), 0);
    do_en = 1'b1;
    @(posedge clock);
    #1 do_en = 1'b0;
    chk("B_err_after", 32'(err), 1);
    repeat (4) @(posedge clock);
    #1;
    chk("B_no_extra", got_q.size(), 0);
    chk("B_done_valid", 32'(dout_valid), 0);

    // Wrap: tail 0x7FFF/0x8000 plus 0x0001/0xFFFF.
    do_reset();
    send(32'h7FFF, 0, 32'h8000, 0, 1'b0, 0);
    drain(HOP, "W1");
    send(1, 0, 32'hFFFF, 0, 1'b0, 0);
    wait_outputs(1);
    chk("W2_first", got_q[0], 32'h8000_7FFF);
    drain(HOP, "W2");

    // Gapped ramp with a stray strobe and a 5-cycle stall mid-EMIT.
    do_reset();
    send(1, 1, 0, -1, 1'b0, 2);
    wait_outputs(10);
    do_en = 1'b1;
    do_re = 16'h1234;
    do_im = 16'h5678;
    @(posedge clock);
    #1 do_en = 1'b0;
    chk("emit_err", 32'(err), 1);
    dout_ready = 1'b0;
    @(negedge clock);
    h_re = dout_re; h_im = dout_im; h_v = dout_valid;
    stable = 1'b1;
    repeat (5) begin
      @(negedge clock);
      if (dout_re !== h_re || dout_im !== h_im || dout_valid !== h_v) stable = 1'b0;
    end
    chk("bp_stable", 32'(stable), 1);
    chk("bp_valid", 32'(h_v), 1);
    @(posedge clock);
    #1 dout_ready = 1'b1;
    drain(HOP, "R1");
    chk("R1_frame_ready", 32'(frame_ready), 1);
    send(1000, 1, 7, 2, 1'b0, 0);
    drain(HOP, "R2");
    chk("R2_extra", got_q.size(), 0);

    // Reset mid-EMIT, then a final frame of 5s must see a cleared tail.
    send(3, 0, 0, 0, 1'b0, 0);
    wait_outputs(10);
    do_reset();
    send(5, 0, 0, 0, 1'b1, 0);
    drain(HOP + OV, "F");
    chk("F_done", 32'(done), 1);
    chk("F_err", 32'(err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
